// File: rtl/mips_cpu_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit. One multiplier or quotient bit per
// cycle on unsigned magnitudes; signs are applied in a single FINISH cycle.
// Fixed 33-cycle latency from the start edge to the done edge.
//
// state  | meaning
// IDLE   | waiting for start; hi/lo hold the last result
// CALC   | 32 radix-2 iterations, cnt_q counts 0..31
// FINISH | apply signs, register hi/lo, pulse done
module mips_cpu_muldiv (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        div_by_zero
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CALC   = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        is_div_q, is_div_d;
   logic        sa_q, sa_d;
   logic        sb_q, sb_d;
   logic        b_zero_q, b_zero_d;
   // opa holds the multiplicand, or the dividend that is shifted out MSB
   // first while quotient bits shift in from the bottom.
   logic [31:0] opa_q, opa_d;
   // opb holds the multiplier (consumed LSB first) or the divisor.
   logic [31:0] opb_q, opb_d;
   logic [63:0] acc_q, acc_d;
   logic [32:0] rem_q, rem_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        done_q, done_d;
   logic        busy_q, busy_d;
   logic        dz_q, dz_d;

   logic        op_signed;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [32:0] mul_sum;
   logic [32:0] div_shift;
   logic [33:0] div_diff;
   logic [63:0] prod_signed;
   logic [31:0] quo_signed;
   logic [31:0] rem_signed;

   // State and datapath registers, synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         b_zero_q <= 1'b0;
         opa_q    <= '0;
         opb_q    <= '0;
         acc_q    <= '0;
         rem_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         is_div_q <= is_div_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         b_zero_q <= b_zero_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         acc_q    <= acc_d;
         rem_q    <= rem_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         dz_q     <= dz_d;
      end
   end

   // Next-state logic: 32 CALC cycles, exit when the counter wraps 31->0.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = CALC;
         CALC:    if (cnt_q == 5'd31) state_d = FINISH;
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath and output logic for each state.
   always_comb begin
      op_signed   = ~op[0];
      a_mag       = (op_signed && a[31]) ? (32'd0 - a) : a;
      b_mag       = (op_signed && b[31]) ? (32'd0 - b) : b;

      mul_sum     = {1'b0, acc_q[63:32]} + (opb_q[0] ? {1'b0, opa_q} : 33'd0);
      div_shift   = {rem_q[31:0], opa_q[31]};
      div_diff    = {1'b0, div_shift} - {2'b00, opb_q};

      prod_signed = (sa_q ^ sb_q) ? (64'd0 - acc_q) : acc_q;
      quo_signed  = (sa_q ^ sb_q) ? (32'd0 - opa_q) : opa_q;
      rem_signed  = sa_q ? (32'd0 - rem_q[31:0]) : rem_q[31:0];

      cnt_d       = cnt_q;
      is_div_d    = is_div_q;
      sa_d        = sa_q;
      sb_d        = sb_q;
      b_zero_d    = b_zero_q;
      opa_d       = opa_q;
      opb_d       = opb_q;
      acc_d       = acc_q;
      rem_d       = rem_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      dz_d        = dz_q;
      done_d      = 1'b0;
      busy_d      = (state_d != IDLE);

      case (state_q)
         IDLE: begin
            if (start) begin
               is_div_d = op[1];
               sa_d     = op_signed & a[31];
               sb_d     = op_signed & b[31];
               b_zero_d = (b == 32'd0);
               opa_d    = a_mag;
               opb_d    = b_mag;
               acc_d    = '0;
               rem_d    = '0;
               cnt_d    = '0;
            end
         end
         CALC: begin
            cnt_d = cnt_q + 5'd1;
            if (is_div_q) begin
               if (!div_diff[33]) begin
                  rem_d = div_diff[32:0];
                  opa_d = {opa_q[30:0], 1'b1};
               end else begin
                  rem_d = div_shift;
                  opa_d = {opa_q[30:0], 1'b0};
               end
            end else begin
               acc_d = {mul_sum, acc_q[31:1]};
               opb_d = {1'b0, opb_q[31:1]};
            end
         end
         FINISH: begin
            done_d = 1'b1;
            if (is_div_q) begin
               // Remainder magnitude equals |a| when b==0, so re-signing it
               // reproduces the raw dividend; only the quotient is forced.
               hi_d = rem_signed;
               lo_d = b_zero_q ? 32'hFFFF_FFFF : quo_signed;
               dz_d = b_zero_q;
            end else begin
               hi_d = prod_signed[63:32];
               lo_d = prod_signed[31:0];
               dz_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign hi          = hi_q;
   assign lo          = lo_q;
   assign div_by_zero = dz_q;

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Directed bench for mips_cpu_muldiv: arithmetic vectors, latency,
// handshake, back-to-back start and mid-operation reset.
module tb_mips_cpu_muldiv;

   logic        clk;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        div_by_zero;

   int n_chk;
   int n_err;
   int busy_cnt;
   int done_edge;
   int done_cnt;

   mips_cpu_muldiv dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .op          (op),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .hi          (hi),
      .lo          (lo),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Present start for one edge (edge 0); sample busy just after it.
   task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      @(posedge clk);
      #1;
      start    = 1'b0;
      busy_cnt = busy ? 1 : 0;
   endtask

   // Count edges until done; done_edge=-1 on timeout.
   task automatic wait_done();
      done_edge = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            done_edge = i;
            break;
         end
         if (busy) busy_cnt++;
      end
   endtask

   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo,
                         input logic edz);
      launch(o, x, y);
      wait_done();
      chk({tag, " edge"}, 64'(done_edge), 64'd33);
      chk({tag, " hi"}, {32'd0, hi}, {32'd0, ehi});
      chk({tag, " lo"}, {32'd0, lo}, {32'd0, elo});
      chk({tag, " dz"}, {63'd0, div_by_zero}, {63'd0, edz});
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      rst   = 1'b1;
      start = 1'b0;
      op    = 2'b00;
      a     = '0;
      b     = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst busy", {63'd0, busy}, 64'd0);
      chk("rst done", {63'd0, done}, 64'd0);
      chk("rst hi", {32'd0, hi}, 64'd0);
      chk("rst lo", {32'd0, lo}, 64'd0);
      chk("rst dz", {63'd0, div_by_zero}, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // MULTU max*max with busy length and single-cycle done.
      launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done();
      chk("multu edge", 64'(done_edge), 64'd33);
      chk("multu busy cycles", 64'(busy_cnt), 64'd33);
      chk("multu busy in done", {63'd0, busy}, 64'd0);
      chk("multu hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFE);
      chk("multu lo", {32'd0, lo}, 64'h0000_0000_0000_0001);
      @(posedge clk);
      #1;
      chk("multu done width", {63'd0, done}, 64'd0);
      chk("multu hold lo", {32'd0, lo}, 64'h1);

      run_op("mult neg", 2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
      run_op("mult min", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
      run_op("div neg", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      run_op("divu 7/2", 2'b11, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0);
      run_op("divu big", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC, 1'b0);
      run_op("div ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
      run_op("divu by0", 2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
      run_op("div by0", 2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
      run_op("mult dz clr", 2'b00, 32'd6, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 1'b0);

      // start held high with operands churning during busy.
      @(negedge clk);
      start = 1'b1;
      op    = 2'b01;
      a     = 32'd3;
      b     = 32'd4;
      @(posedge clk);
      done_edge = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            done_edge = i;
            break;
         end
         a  = $urandom;
         b  = $urandom;
         op = 2'($urandom_range(0, 3));
      end
      start = 1'b0;
      chk("hold edge", 64'(done_edge), 64'd33);
      chk("hold hi", {32'd0, hi}, 64'd0);
      chk("hold lo", {32'd0, lo}, 64'd12);
      done_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (done) done_cnt++;
      end
      chk("hold one done", 64'(done_cnt), 64'd0);

      // Back-to-back: issue start in the done cycle.
      launch(2'b01, 32'd5, 32'd7);
      wait_done();
      chk("b2b first lo", {32'd0, lo}, 64'd35);
      start = 1'b1;
      op    = 2'b11;
      a     = 32'd100;
      b     = 32'd7;
      @(posedge clk);
      #1;
      start    = 1'b0;
      busy_cnt = 0;
      chk("b2b busy rise", {63'd0, busy}, 64'd1);
      chk("b2b done fall", {63'd0, done}, 64'd0);
      wait_done();
      chk("b2b edge", 64'(done_edge), 64'd33);
      chk("b2b hi", {32'd0, hi}, 64'd2);
      chk("b2b lo", {32'd0, lo}, 64'd14);

      // Reset at edge 10 of an operation.
      launch(2'b01, 32'd2, 32'd3);
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst mid busy", {63'd0, busy}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (done) done_cnt++;
      end
      chk("rst mid no done", 64'(done_cnt), 64'd0);
      chk("rst mid hi", {32'd0, hi}, 64'd0);
      chk("rst mid lo", {32'd0, lo}, 64'd0);
      run_op("after rst", 2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
